// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bus interface for the scoreboarded register file.
//
// Purpose : groups the read, write and reservation signals of regfile_sb
//           so the register file and its client share one port list.
// Params  : N data width, R address width (depth 2**R).
// Modports:
//   master - the client: drives rdEn/readReg1/readReg2, writeEnable/
//            writeReg/writeData and reserveEn/reserveReg; samples
//            readData1/readData2/readValid, busy1/busy2, hazard and
//            reserveErr.
//   slave  - the register file: the mirror image of master.
interface regfile_sb_if #(
  parameter int N = 32,
  parameter int R = 5
);
  logic         rdEn;
  logic [R-1:0] readReg1;
  logic [R-1:0] readReg2;
  logic         writeEnable;
  logic [R-1:0] writeReg;
  logic [N-1:0] writeData;
  logic         reserveEn;
  logic [R-1:0] reserveReg;
  logic [N-1:0] readData1;
  logic [N-1:0] readData2;
  logic         readValid;
  logic         busy1;
  logic         busy2;
  logic         hazard;
  logic         reserveErr;

  modport master (
    output rdEn, readReg1, readReg2,
    output writeEnable, writeReg, writeData,
    output reserveEn, reserveReg,
    input  readData1, readData2, readValid,
    input  busy1, busy2, hazard, reserveErr
  );

  modport slave (
    input  rdEn, readReg1, readReg2,
    input  writeEnable, writeReg, writeData,
    input  reserveEn, reserveReg,
    output readData1, readData2, readValid,
    output busy1, busy2, hazard, reserveErr
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- 2-read / 1-write register file with a pending-write
// scoreboard.
//
// Purpose : 2**R registers of N bits, register 0 hard-wired to zero.
//           Reads are registered (one-cycle latency, readValid pulse).
//           One busy bit per register is set by a reservation and cleared
//           by a write; busy1/busy2/hazard report the current scoreboard
//           for the read addresses, reserveErr flags a double reservation.
// Ports   :
//   clk     - rising-edge clock
//   resetN  - asynchronous active-low reset; clears registers, scoreboard
//             and all registered outputs
//   bus     - regfile_sb_if.slave, read/write/reserve bus
// Options : REGFILE_BYPASS_EN - when defined, a read on the same edge as a
//           write to the same nonzero address returns the write data;
//           otherwise it returns the pre-write contents.
module regfile_sb #(
  parameter int N = 32,
  parameter int R = 5
) (
  input logic          clk,
  input logic          resetN,
  regfile_sb_if.slave  bus
);
  localparam int D = 1 << R;

  logic [N-1:0] regs [D];
  logic [D-1:0] busy;
  logic [D-1:0] busy_nxt;
  logic [N-1:0] rd_val1;
  logic [N-1:0] rd_val2;
  logic         err_nxt;

  always_comb begin
    rd_val1 = regs[bus.readReg1];
    rd_val2 = regs[bus.readReg2];
`ifdef REGFILE_BYPASS_EN
    // write-through: the word being written this edge wins over the array
    if (bus.writeEnable && bus.writeReg == bus.readReg1 && bus.readReg1 != '0)
      rd_val1 = bus.writeData;
    if (bus.writeEnable && bus.writeReg == bus.readReg2 && bus.readReg2 != '0)
      rd_val2 = bus.writeData;
`endif
  end

  // register 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < D; i++) regs[i] <= '0;
    end else if (bus.writeEnable && bus.writeReg != '0) begin
      regs[bus.writeReg] <= bus.writeData;
    end
  end

  // clear first, then set, so a same-edge reserve of the written address wins
  always_comb begin
    busy_nxt = busy;
    if (bus.writeEnable) busy_nxt[bus.writeReg] = 1'b0;
    if (bus.reserveEn && bus.reserveReg != '0) busy_nxt[bus.reserveReg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    err_nxt = bus.reserveEn && bus.reserveReg != '0 && busy[bus.reserveReg]
              && !(bus.writeEnable && bus.writeReg == bus.reserveReg);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busy           <= '0;
      bus.readData1  <= '0;
      bus.readData2  <= '0;
      bus.readValid  <= 1'b0;
      bus.reserveErr <= 1'b0;
    end else begin
      busy           <= busy_nxt;
      bus.readValid  <= bus.rdEn;
      bus.reserveErr <= err_nxt;
      if (bus.rdEn) begin
        bus.readData1 <= rd_val1;
        bus.readData2 <= rd_val2;
      end
    end
  end

  // scoreboard view is the registered state only; no same-cycle forwarding
  assign bus.busy1  = busy[bus.readReg1];
  assign bus.busy2  = busy[bus.readReg2];
  assign bus.hazard = bus.rdEn & (bus.busy1 | bus.busy2);

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter N, default 32: data width in bits.
REQ-002 Parameter R, default 5: address width in bits; depth is 2**R registers.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
  clk  input  1  rising-edge clock
  resetN  input  1  asynchronous active-low reset
  rdEn  input  1  read request; both read ports sampled this edge
  readReg1  input  R  read port 1 address
  readReg2  input  R  read port 2 address
  writeEnable  input  1  write strobe
  writeReg  input  R  write address
  writeData  input  N  write data
  reserveEn  input  1  mark reserveReg as pending-write
  reserveReg  input  R  scoreboard reservation address
  readData1  output  N  registered read data, port 1
  readData2  output  N  registered read data, port 2
  readValid  output  1  one-cycle pulse: readData1/2 updated
  busy1  output  1  combinational scoreboard bit for readReg1
  busy2  output  1  combinational scoreboard bit for readReg2
  hazard  output  1  combinational: rdEn & (busy1 | busy2)
  reserveErr  output  1  registered one-cycle pulse: double reservation

Function
REQ-004 Register 0 SHALL always read as zero; writes and reservations to address 0 SHALL be ignored; busy for address 0 SHALL always be 0.
REQ-005 On a rising edge with writeEnable=1 and writeReg!=0, registers[writeReg] SHALL take writeData.
REQ-006 On a rising edge with rdEn=1, readData1/readData2 SHALL load the contents at readReg1/readReg2, visible in the following cycle (1-cycle latency), and readValid SHALL be 1 for exactly that following cycle.
REQ-007 With rdEn=0, readData1/readData2 SHALL hold their previous values and readValid SHALL be 0.
REQ-008 Read and write of the same nonzero address on the same edge: the returned value SHALL follow REQ-020/REQ-021.
REQ-009 The scoreboard SHALL hold one busy bit per register.
REQ-010 On an edge with reserveEn=1 and reserveReg!=0, busy[reserveReg] SHALL be set.
REQ-011 On an edge with writeEnable=1, busy[writeReg] SHALL be cleared.
REQ-012 On the same edge with reserveEn and writeEnable to the same nonzero address, the set SHALL win: busy remains 1 and the data write still occurs.
REQ-013 busy1/busy2 SHALL reflect the current scoreboard state with no same-cycle forwarding of reserve or clear.
REQ-014 hazard SHALL be asserted combinationally; the block does not stall internally and SHALL still perform the read.
REQ-015 reserveErr SHALL pulse for one cycle after an edge on which reserveEn targeted a nonzero register already busy, unless writeEnable cleared that same register on that edge.
REQ-016 Arithmetic on addresses SHALL be modulo 2**R; no out-of-range address exists.

Reset
REQ-017 While resetN=0, all registers, all busy bits, readData1, readData2, readValid and reserveErr SHALL be 0, independent of clk.
REQ-018 Reset assertion mid-operation SHALL discard any in-flight read or write on that edge.
REQ-019 After resetN rises, the first rising edge SHALL behave as a normal operating edge.

Configuration
REQ-020 With REGFILE_BYPASS_EN defined, a read of address A on an edge that also writes nonzero A SHALL return writeData (write-through bypass).
REQ-021 Without REGFILE_BYPASS_EN, that read SHALL return the pre-write contents; the new value SHALL be visible on the next read.

Verification
REQ-022 Reset: hold resetN=0, then release -> all outputs 0; reading all 32 addresses returns 0.
REQ-023 Write 0xDEADBEEF to reg 5, then rdEn with readReg1=5 and readReg2=0 -> next cycle readData1=0xDEADBEEF, readData2=0, readValid high for exactly 1 cycle.
REQ-024 Same edge: write 0x12345678 to reg 7 and read reg 7 -> readData1=0x12345678 with the macro defined, or the prior value (0) without it.
REQ-025 Reserve reg 3 -> busy1=1 with readReg1=3; rdEn gives hazard=1; reserve reg 3 again -> reserveErr pulses once; write reg 3 -> busy1=0.
REQ-026 Same edge: reserve and write reg 9 -> reg 9 holds writeData, busy stays 1, no reserveErr; write reg 0 with 0xFFFFFFFF -> reading reg 0 returns 0.
